// File: rtl/mux2_sel_arbiter_pkg.sv
// Shared types for the 2:1 mux select arbiter: FSM state encoding and source identifiers.
package mux2_sel_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G1   = 2'd1,
        G2   = 2'd2
    } state_e;

    typedef enum logic {
        SRC1 = 1'b0,
        SRC2 = 1'b1
    } src_e;

    // Grant state that serves a given source.
    function automatic state_e grant_state(src_e src);
        return (src == SRC1) ? G1 : G2;
    endfunction

endpackage

// File: rtl/mux2_burst_counter.sv
// Beat counter for one grant burst; clr has priority over inc, at_max flags the last beat.
module mux2_burst_counter
    import mux2_sel_arbiter_pkg::*;
#(
    parameter int BURST = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          at_max
);

    localparam logic [CW-1:0] MAX = CW'(BURST - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == MAX);

endmodule

// File: rtl/mux2_sel_arbiter.sv
// Round-robin burst arbiter that drives a registered, burst-stable select for a 2:1 mux.
//
// state | meaning
// IDLE  | no grant; s holds its last value
// G1    | source 1 (mux input x1) granted, s = 0
// G2    | source 2 (mux input x2) granted, s = 1
module mux2_sel_arbiter
    import mux2_sel_arbiter_pkg::*;
#(
    parameter int BURST = 4,
    parameter int CW    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req1,
    input  logic req2,
    input  logic rdy,
    output logic s,
    output logic gnt1,
    output logic gnt2,
    output logic beat
);

    state_e state_q, state_d;
    src_e   last_q,  last_d;
    logic   s_q,     s_d;
    logic   gnt1_q,  gnt1_d;
    logic   gnt2_q,  gnt2_d;

    logic          cnt_clr;
    logic          cnt_inc;
    logic          cnt_at_max;
    logic [CW-1:0] cnt_unused;

    logic   own_req;
    logic   oth_req;
    src_e   own_src;
    state_e oth_state;
    logic   burst_end;

    mux2_burst_counter #(
        .BURST (BURST),
        .CW    (CW)
    ) u_burst_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .cnt    (cnt_unused),
        .at_max (cnt_at_max)
    );

    assign beat = ((gnt1_q & req1) | (gnt2_q & req2)) & rdy;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        own_req   = 1'b0;
        oth_req   = 1'b0;
        own_src   = SRC1;
        oth_state = G2;
        burst_end = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (req1 && req2) begin
                    state_d = (last_q == SRC2) ? G1 : G2;
                end else if (req1) begin
                    state_d = G1;
                end else if (req2) begin
                    state_d = G2;
                end
            end
            G1, G2: begin
                own_req   = (state_q == G1) ? req1 : req2;
                oth_req   = (state_q == G1) ? req2 : req1;
                own_src   = (state_q == G1) ? SRC1 : SRC2;
                oth_state = (state_q == G1) ? G2 : G1;
                // A beat on the final count and a dropped request both close the burst.
                burst_end = (beat && cnt_at_max) || !own_req;
                if (burst_end) begin
                    cnt_clr = 1'b1;
                    last_d  = own_src;
                    if (oth_req) begin
                        state_d = oth_state;
                    end else if (own_req) begin
                        state_d = grant_state(own_src);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_inc = beat;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_comb begin
        s_d    = s_q;
        gnt1_d = (state_d == G1);
        gnt2_d = (state_d == G2);
        if (state_d == G1) begin
            s_d = 1'b0;
        end else if (state_d == G2) begin
            s_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= SRC2;
            s_q     <= 1'b0;
            gnt1_q  <= 1'b0;
            gnt2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            s_q     <= s_d;
            gnt1_q  <= gnt1_d;
            gnt2_q  <= gnt2_d;
        end
    end

    assign s    = s_q;
    assign gnt1 = gnt1_q;
    assign gnt2 = gnt2_q;

endmodule

// File: tb/tb_mux2_sel_arbiter.sv
// Scoreboard bench for mux2_sel_arbiter: BURST=4 instance and a BURST=1 instance.
module tb_mux2_sel_arbiter;

    logic clk = 1'b0;
    logic rst;

    logic a_req1, a_req2, a_rdy, a_s, a_g1, a_g2, a_beat;
    logic b_req1, b_req2, b_rdy, b_s, b_g1, b_g2, b_beat;

    typedef struct {
        logic  beat;
        logic  s;
        logic  g1;
        logic  g2;
        string tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mux2_sel_arbiter #(.BURST(4), .CW(3)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .req1 (a_req1),
        .req2 (a_req2),
        .rdy  (a_rdy),
        .s    (a_s),
        .gnt1 (a_g1),
        .gnt2 (a_g2),
        .beat (a_beat)
    );

    mux2_sel_arbiter #(.BURST(1), .CW(1)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .req1 (b_req1),
        .req2 (b_req2),
        .rdy  (b_rdy),
        .s    (b_s),
        .gnt1 (b_g1),
        .gnt2 (b_g2),
        .beat (b_beat)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Each step drives one cycle of inputs and queues what that cycle must show.
    task automatic step_a(input string tag, input logic r1, input logic r2, input logic rd,
                          input logic eb, input logic es, input logic e1, input logic e2);
        @(posedge clk);
        #1;
        a_req1 = r1;
        a_req2 = r2;
        a_rdy  = rd;
        qa.push_back('{beat: eb, s: es, g1: e1, g2: e2, tag: tag});
    endtask

    task automatic step_b(input string tag, input logic r1, input logic r2, input logic rd,
                          input logic eb, input logic es, input logic e1, input logic e2);
        @(posedge clk);
        #1;
        b_req1 = r1;
        b_req2 = r2;
        b_rdy  = rd;
        qb.push_back('{beat: eb, s: es, g1: e1, g2: e2, tag: tag});
    endtask

    always @(negedge clk) begin : monitor_a
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk({e.tag, " A.beat"}, a_beat, e.beat);
            chk({e.tag, " A.s"},    a_s,    e.s);
            chk({e.tag, " A.gnt1"}, a_g1,   e.g1);
            chk({e.tag, " A.gnt2"}, a_g2,   e.g2);
        end
    end

    always @(negedge clk) begin : monitor_b
        exp_t e;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk({e.tag, " B.beat"}, b_beat, e.beat);
            chk({e.tag, " B.s"},    b_s,    e.s);
            chk({e.tag, " B.gnt1"}, b_g1,   e.g1);
            chk({e.tag, " B.gnt2"}, b_g2,   e.g2);
        end
    end

    always @(negedge clk) begin
        assert (!(a_g1 && a_g2) && !(b_g1 && b_g2))
            else $error("both grants high: A=%0b%0b B=%0b%0b", a_g1, a_g2, b_g1, b_g2);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        a_req1 = 1'b0; a_req2 = 1'b0; a_rdy = 1'b0;
        b_req1 = 1'b0; b_req2 = 1'b0; b_rdy = 1'b0;
        #12;
        chk("por A.s",    a_s,  1'b0);
        chk("por A.gnt1", a_g1, 1'b0);
        chk("por A.gnt2", a_g2, 1'b0);
        chk("por B.gnt1", b_g1, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        step_a("idle", 0, 0, 0, 0, 0, 0, 0);

        // req1 alone: 4-beat burst, immediate re-grant, s stays 0
        step_a("t2 req", 1, 0, 1, 0, 0, 0, 0);
        repeat (6) step_a("t2 g1", 1, 0, 1, 1, 0, 1, 0);
        step_a("t2 drop", 0, 0, 1, 0, 0, 1, 0);
        step_a("t2 idle", 0, 0, 0, 0, 0, 0, 0);

        // build a G2 burst to cnt=2, then reset asynchronously mid-cycle
        step_a("t1 req", 0, 1, 1, 0, 0, 0, 0);
        repeat (2) step_a("t1 g2", 0, 1, 1, 1, 1, 0, 1);
        @(posedge clk);
        #1;
        a_req1 = 1'b0; a_req2 = 1'b0; a_rdy = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("t1 rst A.s",    a_s,    1'b0);
        chk("t1 rst A.gnt1", a_g1,   1'b0);
        chk("t1 rst A.gnt2", a_g2,   1'b0);
        chk("t1 rst A.beat", a_beat, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // both requesting after reset: source 1 first, then alternate every 4 beats
        step_a("t3 req", 1, 1, 1, 0, 0, 0, 0);
        repeat (4) step_a("t3 g1a", 1, 1, 1, 1, 0, 1, 0);
        repeat (4) step_a("t3 g2",  1, 1, 1, 1, 1, 0, 1);
        repeat (4) step_a("t3 g1b", 1, 1, 1, 1, 0, 1, 0);
        step_a("t3 drop", 0, 0, 1, 0, 1, 0, 1);
        step_a("t3 idle s hold", 0, 0, 0, 0, 1, 0, 0);

        // stall mid-burst: count freezes at 2, two more beats finish the burst
        step_a("t4 req", 1, 0, 1, 0, 1, 0, 0);
        repeat (2) step_a("t4 g1", 1, 0, 1, 1, 0, 1, 0);
        repeat (5) step_a("t4 stall", 1, 0, 0, 0, 0, 1, 0);
        repeat (2) step_a("t4 resume", 1, 1, 1, 1, 0, 1, 0);
        repeat (4) step_a("t4 g2", 1, 1, 1, 1, 1, 0, 1);
        repeat (2) step_a("t5 g1", 1, 1, 1, 1, 0, 1, 0);

        // req1 drops after 2 beats with req2 high: straight to G2
        step_a("t5 drop", 0, 1, 1, 0, 0, 1, 0);
        step_a("t5 g2",   0, 1, 1, 1, 1, 0, 1);
        step_a("t5 end",  0, 0, 0, 0, 1, 0, 1);
        step_a("t5 idle", 0, 0, 0, 0, 1, 0, 0);

        // BURST=1: strict alternation, stall holds the grant
        step_b("t6 req",   1, 1, 1, 0, 0, 0, 0);
        step_b("t6 g1a",   1, 1, 1, 1, 0, 1, 0);
        step_b("t6 g2a",   1, 1, 1, 1, 1, 0, 1);
        step_b("t6 g1b",   1, 1, 1, 1, 0, 1, 0);
        step_b("t6 g2b",   1, 1, 1, 1, 1, 0, 1);
        step_b("t6 stall", 1, 1, 0, 0, 0, 1, 0);
        step_b("t6 g1c",   1, 1, 1, 1, 0, 1, 0);
        step_b("t6 g2c",   1, 1, 1, 1, 1, 0, 1);
        step_b("t6 drop",  0, 0, 0, 0, 0, 1, 0);
        step_b("t6 idle",  0, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending A=%0d B=%0d expected 0", qa.size(), qb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
